// File: rtl/mul_acc_pipe.sv
// Fixed-latency pipelined WIDTH x WIDTH multiplier with per-issue accumulate.
// Optional build macro MUL_ACC_PIPE_SAT_EN: saturate the final sum instead of wrapping.
module mul_acc_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3,
  parameter int SIGNED  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc,
  output logic [WIDTH-1:0] out,
  output logic             t_out
);
  localparam int PW        = 2 * WIDTH;
  localparam bit IS_SIGNED = (SIGNED != 0);

  logic             s1_valid_reg;
  logic             s1_acc_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      s1_acc_reg   <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
    end else begin
      s1_valid_reg <= t;
      if (t) begin
        s1_acc_reg <= acc;
        s1_a_reg   <= a;
        s1_b_reg   <= b;
      end
    end
  end

  // Extending both operands to PW bits makes one unsigned multiply exact for either signedness.
  logic [PW-1:0] a_x;
  logic [PW-1:0] b_x;
  logic [PW-1:0] prod;

  assign a_x  = {{WIDTH{IS_SIGNED & s1_a_reg[WIDTH-1]}}, s1_a_reg};
  assign b_x  = {{WIDTH{IS_SIGNED & s1_b_reg[WIDTH-1]}}, s1_b_reg};
  assign prod = a_x * b_x;

  logic          fin_valid;
  logic          fin_acc;
  logic [PW-1:0] fin_prod;

  generate
    if (LATENCY == 2) begin : g_direct
      assign fin_valid = s1_valid_reg;
      assign fin_acc   = s1_acc_reg;
      assign fin_prod  = prod;
    end else begin : g_delay
      localparam int DEPTH = LATENCY - 2;

      logic [DEPTH-1:0] dly_valid_reg;
      logic [DEPTH-1:0] dly_acc_reg;
      logic [PW-1:0]    dly_prod_reg [DEPTH];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dly_valid_reg <= '0;
          dly_acc_reg   <= '0;
          for (int i = 0; i < DEPTH; i++) begin
            dly_prod_reg[i] <= '0;
          end
        end else begin
          dly_valid_reg[0] <= s1_valid_reg;
          dly_acc_reg[0]   <= s1_acc_reg;
          dly_prod_reg[0]  <= prod;
          for (int i = 1; i < DEPTH; i++) begin
            dly_valid_reg[i] <= dly_valid_reg[i-1];
            dly_acc_reg[i]   <= dly_acc_reg[i-1];
            dly_prod_reg[i]  <= dly_prod_reg[i-1];
          end
        end
      end

      assign fin_valid = dly_valid_reg[DEPTH-1];
      assign fin_acc   = dly_acc_reg[DEPTH-1];
      assign fin_prod  = dly_prod_reg[DEPTH-1];
    end
  endgenerate

  // The output register doubles as the accumulator: both load the same value on the same edges.
  logic [WIDTH-1:0] res_reg;
  logic             t_out_reg;
  logic [PW:0]      prod_x;
  logic [PW:0]      acc_x;
  logic [PW:0]      sum;
  logic [WIDTH-1:0] res_next;

  assign prod_x = {IS_SIGNED & fin_prod[PW-1], fin_prod};
  assign acc_x  = {{(WIDTH+1){IS_SIGNED & res_reg[WIDTH-1]}}, res_reg};
  assign sum    = fin_acc ? (acc_x + prod_x) : prod_x;

`ifdef MUL_ACC_PIPE_SAT_EN
  always_comb begin
    res_next = sum[WIDTH-1:0];
    if (IS_SIGNED) begin
      if (!sum[PW] && (|sum[PW:WIDTH-1])) begin
        res_next = {1'b0, {(WIDTH-1){1'b1}}};
      end else if (sum[PW] && !(&sum[PW:WIDTH-1])) begin
        res_next = {1'b1, {(WIDTH-1){1'b0}}};
      end
    end else if (|sum[PW:WIDTH]) begin
      res_next = '1;
    end
  end
`else
  logic unused_sum_hi;
  assign unused_sum_hi = ^sum[PW:WIDTH];
  assign res_next      = sum[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_reg   <= '0;
      t_out_reg <= 1'b0;
    end else begin
      t_out_reg <= fin_valid;
      if (fin_valid) begin
        res_reg <= res_next;
      end
    end
  end

  assign out   = res_reg;
  assign t_out = t_out_reg;

endmodule

// File: tb/tb_mul_acc_pipe.sv
// Scoreboard bench for mul_acc_pipe: four builds (unsigned/signed, latency 2/3/6) share one stimulus stream.
module tb_mul_acc_pipe;
  localparam int N = 4;

  typedef struct packed {
    int          due;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        t;
  logic        acc;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] out_w  [N];
  logic        tout_w [N];

  exp_t        q [N][$];
  logic [31:0] model_acc [N];
  logic [31:0] last_out  [N];
  int          cyc    = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      mul_acc_pipe #(
        .WIDTH  (32),
        .LATENCY((gi == 2) ? 2 : (gi == 3) ? 6 : 3),
        .SIGNED ((gi == 1 || gi == 3) ? 1 : 0)
      ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .t    (t),
        .a    (a),
        .b    (b),
        .acc  (acc),
        .out  (out_w[gi]),
        .t_out(tout_w[gi])
      );
    end
  endgenerate

  function automatic int lat_of(input int i);
    return (i == 2) ? 2 : (i == 3) ? 6 : 3;
  endfunction

  function automatic bit sgn_of(input int i);
    return (i == 1) || (i == 3);
  endfunction

  function automatic logic [31:0] ref_fn(input bit sgn, input logic [31:0] accv,
                                         input logic [31:0] av, input logic [31:0] bv,
                                         input bit cm);
    logic signed [65:0] p;
    logic signed [65:0] ae;
    logic signed [65:0] s;
    if (sgn) begin
      p  = $signed({{34{av[31]}}, av}) * $signed({{34{bv[31]}}, bv});
      ae = $signed({{34{accv[31]}}, accv});
    end else begin
      p  = $signed({34'd0, av}) * $signed({34'd0, bv});
      ae = $signed({34'd0, accv});
    end
    s = cm ? (ae + p) : p;
`ifdef MUL_ACC_PIPE_SAT_EN
    if (sgn) begin
      if (s > 66'sh7FFFFFFF) s = 66'sh7FFFFFFF;
      else if (s < -66'sh80000000) s = -66'sh80000000;
    end else if (s > 66'sh0FFFFFFFF) begin
      s = 66'sh0FFFFFFFF;
    end
`endif
    return s[31:0];
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit tv, input logic [31:0] av, input logic [31:0] bv, input bit cv);
    exp_t e;
    t   = tv;
    a   = av;
    b   = bv;
    acc = cv;
    if (tv) begin
      for (int i = 0; i < N; i++) begin
        e.val        = ref_fn(sgn_of(i), model_acc[i], av, bv, cv);
        e.due        = cyc + lat_of(i);
        model_acc[i] = e.val;
        q[i].push_back(e);
      end
      $display("issue cyc=%0d a=%h b=%h acc=%0d", cyc, av, bv, cv);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic flush_model();
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      model_acc[i] = '0;
      last_out[i]  = '0;
    end
  endtask

  // Every falling edge: t_out must match the scoreboard head, out must match the last expected value.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst) begin
        check_val($sformatf("u%0d.rst_out@%0d", i, cyc), out_w[i], 32'd0);
        check_val($sformatf("u%0d.rst_tout@%0d", i, cyc), {31'd0, tout_w[i]}, 32'd0);
      end else begin
        bit ev;
        exp_t e;
        ev = (q[i].size() > 0) && (q[i][0].due == cyc);
        check_val($sformatf("u%0d.tout@%0d", i, cyc), {31'd0, tout_w[i]}, {31'd0, ev});
        if (ev) begin
          e           = q[i].pop_front();
          last_out[i] = e.val;
        end
        check_val($sformatf("u%0d.out@%0d", i, cyc), out_w[i], last_out[i]);
      end
    end
  end

  initial begin
    rst = 1'b0;
    t   = 1'b0;
    a   = '0;
    b   = '0;
    acc = 1'b0;
    flush_model();
    #1;
    for (int i = 0; i < N; i++) begin
      check_val($sformatf("u%0d.init_out", i), out_w[i], 32'd0);
      check_val($sformatf("u%0d.init_tout", i), {31'd0, tout_w[i]}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);

    drive(1'b1, 32'd7, 32'd6, 1'b0);
    idle(7);
    drive(1'b1, 32'hFFFFFFFD, 32'd5, 1'b0);
    idle(7);
    drive(1'b1, 32'd2, 32'd3, 1'b0);
    drive(1'b1, 32'd4, 32'd5, 1'b1);
    drive(1'b1, 32'd1, 32'd1, 1'b1);
    idle(7);
    drive(1'b1, 32'h00010000, 32'h00010000, 1'b0);
    idle(7);
    drive(1'b1, 32'h7FFFFFFF, 32'd2, 1'b0);
    idle(7);
    drive(1'b1, 32'h80000000, 32'h80000000, 1'b1);
    idle(7);

    // Reset asserted between edges while an issue is in flight.
    drive(1'b1, 32'd9, 32'd9, 1'b0);
    #3;
    rst = 1'b0;
    flush_model();
    #1;
    for (int i = 0; i < N; i++) begin
      check_val($sformatf("u%0d.async_out", i), out_w[i], 32'd0);
      check_val($sformatf("u%0d.async_tout", i), {31'd0, tout_w[i]}, 32'd0);
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(6);
    drive(1'b1, 32'd3, 32'd3, 1'b1);
    idle(7);

    for (int k = 0; k < 300; k++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      drive(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)));
    end
    idle(8);

    for (int i = 0; i < N; i++) begin
      check_val($sformatf("u%0d.drain", i), 32'(q[i].size()), 32'd0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_acc_pipe.md
Name: mul_acc_pipe

Overview:
Parametrised, fixed-latency, fully pipelined integer multiplier with an optional per-issue accumulate mode. It is the successor to the fixed 32-bit, fixed-latency multiplier helpers, and is intended for statically scheduled HIR datapaths. An issue happens when the time pulse `t` is high. The result appears exactly LATENCY cycles later, qualified by `t_out`. There are no stalls and no backpressure; the schedule guarantees timing.

Parameters:
- WIDTH, 32: operand and result width in bits; must be >= 2.
- LATENCY, 3: cycles from the issue edge to the result; must be >= 2. Stage 1 is the input register; stage LATENCY is the accumulate/output register.
- SIGNED, 0: 1 = two's-complement operands and result; 0 = unsigned.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low: rst==0 clears all state immediately.
- t  input  1  issue pulse; a, b and acc are sampled on any rising edge where t==1.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- acc  input  1  1 = add the product to the accumulator; 0 = load the product (starts a new sum).
- out  output  WIDTH  registered result; holds its value between valid outputs.
- t_out  output  1  one-cycle pulse; high in the cycle `out` carries the result of the issue LATENCY cycles earlier.

Behaviour:
- Reset (rst==0, asynchronous):
  - out=0, t_out=0, accumulator register=0.
  - All pipeline valid bits=0; pipeline data registers are also cleared.
  - Takes effect without a clock edge.
- Reset mid-operation: all in-flight issues are discarded. After rst returns high, t_out stays 0 until LATENCY cycles after the first new issue.
- Pipeline:
  - A valid bit travels with each issue through LATENCY stages.
  - The full 2*WIDTH product is formed in stage 2.
  - Registers in stages 2..LATENCY-1 only delay the data; they do no arithmetic.
  - With LATENCY==2, the product is formed combinationally into the final stage.
- Throughput: one issue per cycle. Issues on every consecutive cycle are legal and each produces exactly one t_out pulse.
- Arithmetic:
  - The product is signed or unsigned per SIGNED, computed at 2*WIDTH bits with no loss.
  - Final stage, acc==0: sum = product.
  - Final stage, acc==1: sum = ext(acc_reg) + product, computed at 2*WIDTH+1 bits. ext is sign-extension if SIGNED, otherwise zero-extension.
  - The result is the low WIDTH bits of sum (wrap-around), unless the optional feature below is enabled.
- Accumulator:
  - acc_reg is loaded with the final result on every valid final-stage edge.
  - It is unchanged on cycles with no valid final-stage entry.
  - Because the feedback is a single cycle, back-to-back accumulating issues chain correctly: issue n+1 sees the result of issue n.
- acc==1 on the first issue after reset accumulates onto 0.
- Output hold: when the final stage is not valid, out keeps its last value and t_out=0.
- t held high for N cycles counts as N issues.
- Inputs sampled while t==0 are ignored.

Optional Feature:
Macro `MUL_ACC_PIPE_SAT_EN`.
- Defined: the final sum saturates to the WIDTH range instead of wrapping.
  - Unsigned: values > 2^WIDTH-1 become 2^WIDTH-1.
  - Signed: clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - The saturated value is what is stored in acc_reg.
- Undefined: low-WIDTH-bit truncation; no saturation logic is instantiated.
- Latency is identical in both builds.

Test Plan:
1. WIDTH=32, LATENCY=3, SIGNED=0; a=7, b=6, acc=0, t pulsed at cycle 0 -> t_out=1 and out=42 at cycle 3; out holds 42 at cycle 4 with t_out=0.
2. SIGNED=1; a=-3 (0xFFFFFFFD), b=5, acc=0 -> out=0xFFFFFFF1 (-15).
3. Consecutive issues (2,3,acc=0), (4,5,acc=1), (1,1,acc=1) at cycles 0,1,2 -> t_out high at cycles 3,4,5 with out=6, 26, 27.
4. SIGNED=0; a=b=0x00010000 -> out=0x00000000 without the macro; out=0xFFFFFFFF with `MUL_ACC_PIPE_SAT_EN`.
   - SIGNED=1 with the macro: a=0x7FFFFFFF, b=2 -> out=0x7FFFFFFF.
5. Issue at cycle 0, assert rst=0 asynchronously mid-cycle 1 (between edges) -> out=0 and t_out=0 immediately.
   - No t_out at cycle 3.
   - After release, issue (3,3,acc=1) -> out=9, since the accumulator was cleared.
6. LATENCY=2 and LATENCY=6 builds; a random stream with 50% t density -> every t_out lands exactly LATENCY cycles after its issue and matches the reference model for both acc values.
